// File: rtl/clk_div_monitor.sv
// clk_div_monitor: health monitor for an integer / half-integer clock divider.
// Runs on the divider's source clock, treats the divided clock as data and
// measures how many source cycles MEAS_PERIODS divided periods take. It flags
// out-of-range measurements (freq_err) and a divider that stopped toggling
// (stuck_err).
module clk_div_monitor #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MEAS_PERIODS = 2,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_mon,
    input  logic [CNT_W-1:0] exp_min,
    input  logic [CNT_W-1:0] exp_max,
    input  logic             err_clr,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             freq_err,
    output logic             stuck_err,
    output logic             busy
);

    localparam int unsigned EDGE_W = (MEAS_PERIODS > 1) ? $clog2(MEAS_PERIODS) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(MEAS_PERIODS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_q_d;
    logic                   rise;
    logic [CNT_W-1:0]       cyc_cnt;
    logic [CNT_W-1:0]       cyc_inc;
    logic [EDGE_W-1:0]      edge_cnt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   timeout_hit;
    logic                   out_of_range;

    // Synchronize the divided clock into the source domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], clk_mon};
        end
    end

    // Delayed copy of the synchronized clock for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q_d <= 1'b0;
        end else begin
            sync_q_d <= sync_chain[SYNC_STAGES-1];
        end
    end

    // Edge detect, saturating increment, range compare and idle timeout.
    always_comb begin
        rise         = sync_chain[SYNC_STAGES-1] & ~sync_q_d;
        cyc_inc      = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CNT_W'(1);
        out_of_range = (meas_cnt < exp_min) || (meas_cnt > exp_max);
        timeout_hit  = (state != IDLE) && en && !rise && (idle_cnt == IDLE_LAST);
    end

    // Measurement FSM with counters, sticky error flags and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            edge_cnt   <= '0;
            idle_cnt   <= '0;
            meas_cnt   <= '0;
            meas_valid <= 1'b0;
            freq_err   <= 1'b0;
            stuck_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            // Range check runs on the meas_cnt published in the meas_valid
            // cycle; a new set beats a simultaneous clear.
            freq_err   <= (freq_err & ~err_clr) | (meas_valid & out_of_range);
            stuck_err  <= (stuck_err & ~err_clr) | timeout_hit;
            // The next state is ARM or MEASURE exactly when en is high.
            busy       <= en;

            case (state)
                IDLE: begin
                    cyc_cnt  <= '0;
                    edge_cnt <= '0;
                    idle_cnt <= '0;
                    if (en) begin
                        state <= ARM;
                    end
                end

                ARM: begin
                    if (!en) begin
                        state    <= IDLE;
                        cyc_cnt  <= '0;
                        edge_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (rise) begin
                        state    <= MEASURE;
                        cyc_cnt  <= '0;
                        edge_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (timeout_hit) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                MEASURE: begin
                    if (!en) begin
                        state    <= IDLE;
                        cyc_cnt  <= '0;
                        edge_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (rise) begin
                        idle_cnt <= '0;
                        if (edge_cnt == LAST_EDGE) begin
                            // Window closes on this edge and the next one
                            // opens on the same edge.
                            meas_cnt   <= cyc_inc;
                            meas_valid <= 1'b1;
                            cyc_cnt    <= '0;
                            edge_cnt   <= '0;
                        end else begin
                            cyc_cnt  <= cyc_inc;
                            edge_cnt <= edge_cnt + EDGE_W'(1);
                        end
                    end else if (timeout_hit) begin
                        state    <= ARM;
                        cyc_cnt  <= '0;
                        edge_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        cyc_cnt  <= cyc_inc;
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    cyc_cnt  <= '0;
                    edge_cnt <= '0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed + randomized bench for clk_div_monitor with a
// timestamp-based reference model of the measurement rules.
module tb_clk_div_monitor;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned MEAS_PERIODS = 2;
    localparam int unsigned TIMEOUT      = 1023;
    localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clk_mon;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;
    logic             err_clr;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             freq_err;
    logic             stuck_err;
    logic             busy;

    clk_div_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .MEAS_PERIODS(MEAS_PERIODS),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clk_mon   (clk_mon),
        .exp_min   (exp_min),
        .exp_max   (exp_max),
        .err_clr   (err_clr),
        .meas_cnt  (meas_cnt),
        .meas_valid(meas_valid),
        .freq_err  (freq_err),
        .stuck_err (stuck_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus clock: high for w_hi half-cycles, low for w_lo half-cycles.
    int unsigned w_hi = 5;
    int unsigned w_lo = 4;
    int unsigned w_ph = 0;
    bit          w_hold = 1'b0;

    int unsigned n = 0;              // posedges seen
    bit          prev_v = 1'b0;
    int unsigned last_mon_rise = 0;  // posedge at which a sampled clk_mon rise occurred

    // Reference model: state plus timestamps of window start and last activity.
    int          m_state;            // 0 idle, 1 waiting for first edge, 2 measuring
    int unsigned m_start;
    int unsigned m_ref;
    int unsigned m_edges;
    int unsigned m_meas;
    bit          m_valid;
    bit          m_ferr;
    bit          m_serr;
    bit          vh[SYNC_STAGES+2];  // sampled clk_mon history, [0] newest

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, expv, n);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_start = 0; m_ref = 0; m_edges = 0; m_meas = 0;
        m_valid = 1'b0; m_ferr = 1'b0; m_serr = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 2; i++) vh[i] = 1'b0;
    endtask

    task automatic model(input bit v);
        bit rise, set_f, set_s;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = SYNC_STAGES + 1; i > 0; i--) vh[i] = vh[i-1];
            vh[0] = v;
            // A sampled rise becomes visible to the monitor after the synchronizer.
            rise  = vh[SYNC_STAGES] && !vh[SYNC_STAGES+1];
            set_f = m_valid && ((m_meas < 32'(exp_min)) || (m_meas > 32'(exp_max)));
            set_s = 1'b0;
            m_valid = 1'b0;
            if (m_state == 0) begin
                if (en) begin m_state = 1; m_ref = n; end
            end else if (!en) begin
                m_state = 0;
            end else if (rise) begin
                m_ref = n;
                if (m_state == 1) begin
                    m_state = 2; m_start = n; m_edges = 0;
                end else begin
                    m_edges++;
                    if (m_edges == MEAS_PERIODS) begin
                        m_meas  = ((n - m_start) > CNT_MAX) ? CNT_MAX : (n - m_start);
                        m_valid = 1'b1;
                        m_start = n;
                        m_edges = 0;
                    end
                end
            end else if (n - m_ref == TIMEOUT) begin
                set_s = 1'b1; m_state = 1; m_ref = n;
            end
            m_ferr = (m_ferr && !err_clr) || set_f;
            m_serr = (m_serr && !err_clr) || set_s;
        end
    endtask

    task automatic wave_half(output bit v);
        v = !w_hold && (w_ph < w_hi);
        w_ph = (w_ph + 1) % (w_hi + w_lo);
    endtask

    // One clk cycle: two half-cycle drives of clk_mon, then check after posedge.
    task automatic step();
        bit v;
        wave_half(v);
        clk_mon = v;
        @(negedge clk);
        wave_half(v);
        clk_mon = v;
        @(posedge clk);
        #1;
        n++;
        if (v && !prev_v) last_mon_rise = n;
        prev_v = v;
        model(v);
        chk("meas_valid", 32'(meas_valid), 32'(m_valid));
        chk("meas_cnt",   32'(meas_cnt),   m_meas);
        chk("freq_err",   32'(freq_err),   32'(m_ferr));
        chk("stuck_err",  32'(stuck_err),  32'(m_serr));
        chk("busy",       32'(busy),       32'(m_state != 0));
    endtask

    task automatic run_windows(input int unsigned k, input int unsigned limit, input string tag);
        int unsigned seen = 0;
        for (int unsigned i = 0; i < limit && seen < k; i++) begin
            step();
            if (m_valid) seen++;
        end
        chk(tag, seen, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned last_vn;
        int unsigned seen;
        int unsigned stuck_n;
        int unsigned off_cnt;
        int unsigned p;
        int unsigned off_left;

        rst = 1'b0; en = 1'b0; clk_mon = 1'b0; err_clr = 1'b0;
        exp_min = CNT_W'(8); exp_max = CNT_W'(10);
        model_reset();
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_meas_cnt",   32'(meas_cnt),   0);
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_freq_err",   32'(freq_err),   0);
        chk("rst_stuck_err",  32'(stuck_err),  0);
        chk("rst_busy",       32'(busy),       0);
        #2 rst = 1'b0;

        // 1: ratio 4.5, exp 8..10 -> 9 every 9 cycles, no errors.
        w_hi = 5; w_lo = 4; w_ph = 0;
        en = 1'b1;
        seen = 0; last_vn = 0;
        for (int unsigned i = 0; i < 200 && seen < 5; i++) begin
            step();
            if (m_valid) begin
                chk("t1_meas_cnt", 32'(meas_cnt), 9);
                if (seen > 0) chk("t1_interval", n - last_vn, 9);
                last_vn = n;
                seen++;
            end
        end
        chk("t1_windows", seen, 5);
        step();
        chk("t1_freq_err",  32'(freq_err),  0);
        chk("t1_stuck_err", 32'(stuck_err), 0);

        // 2: ratio 4, exp 9..10 -> 8 and sticky freq_err.
        en = 1'b0;
        repeat (3) step();
        w_hi = 4; w_lo = 4; w_ph = 0;
        exp_min = CNT_W'(9); exp_max = CNT_W'(10);
        en = 1'b1;
        run_windows(1, 100, "t2_first_window");
        chk("t2_meas_cnt", 32'(meas_cnt), 8);
        step();
        chk("t2_freq_err_set", 32'(freq_err), 1);
        run_windows(2, 100, "t2_more_windows");
        chk("t2_freq_err_held", 32'(freq_err), 1);

        // 4: clear coinciding with an out-of-range result loses to the set.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_set_wins", 32'(freq_err), 1);
        exp_min = CNT_W'(8); exp_max = CNT_W'(8);
        repeat (2) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_cleared", 32'(freq_err), 0);

        // 3: divided clock stops after 3 windows -> stuck_err TIMEOUT cycles later.
        run_windows(3, 100, "t3_windows");
        w_hold = 1'b1;
        stuck_n = 0;
        for (int unsigned i = 0; i < TIMEOUT + 50; i++) begin
            step();
            if (stuck_err === 1'b1) begin
                stuck_n = n;
                break;
            end
        end
        chk("t3_stuck_cycle", stuck_n, last_mon_rise + SYNC_STAGES + TIMEOUT);
        chk("t3_busy_armed", 32'(busy), 1);
        chk("t3_freq_err", 32'(freq_err), 0);
        w_hold = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        run_windows(2, 100, "t3_recover");
        chk("t3_recover_meas", 32'(meas_cnt), 8);
        chk("t3_stuck_cleared", 32'(stuck_err), 0);

        // 5: en dropped mid-window for 20 cycles.
        w_hi = 5; w_lo = 4; w_ph = 0;
        exp_min = CNT_W'(8); exp_max = CNT_W'(10);
        run_windows(2, 100, "t5_pre");
        repeat (4) step();
        en = 1'b0;
        off_cnt = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            if (meas_valid === 1'b1) off_cnt++;
        end
        chk("t5_no_valid_while_off", off_cnt, 0);
        chk("t5_idle", 32'(busy), 0);
        en = 1'b1;
        run_windows(2, 100, "t5_post");
        chk("t5_meas_cnt", 32'(meas_cnt), 9);

        // 6: async reset mid-window.
        run_windows(1, 100, "t6_pre");
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("t6_async_meas_cnt",   32'(meas_cnt),   0);
        chk("t6_async_meas_valid", 32'(meas_valid), 0);
        chk("t6_async_freq_err",   32'(freq_err),   0);
        chk("t6_async_stuck_err",  32'(stuck_err),  0);
        chk("t6_async_busy",       32'(busy),       0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        run_windows(3, 100, "t6_post");
        chk("t6_meas_cnt", 32'(meas_cnt), 9);

        // Randomized episodes: random divider shape, limits, enable drops, clears.
        for (int ep = 0; ep < 6; ep++) begin
            en = 1'b0;
            repeat (2) step();
            w_hi = $urandom_range(2, 12);
            w_lo = $urandom_range(2, 12);
            w_ph = 0;
            p = w_hi + w_lo;
            if (ep == 5) begin
                exp_min = CNT_W'(p + 3);
                exp_max = CNT_W'(p - 3);
            end else begin
                exp_min = CNT_W'(p - 2 + $urandom_range(0, 3));
                exp_max = CNT_W'(32'(exp_min) + $urandom_range(0, 2));
            end
            off_left = 0;
            for (int unsigned i = 0; i < 400; i++) begin
                if (off_left == 0 && $urandom_range(0, 149) == 0) off_left = $urandom_range(1, 30);
                en = (off_left == 0);
                if (off_left > 0) off_left--;
                err_clr = ($urandom_range(0, 15) == 0);
                step();
            end
            err_clr = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
